// File: rtl/lab3_pkg.sv
// ============================================================================
// Module   : lab3_pkg
// Brief    : Shared types, keymap and column-drive helper for the keypad scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lab3_pkg;

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_EMIT     = 3'd2,
    S_HELD     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  // Indexed [row][col]
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] v;
    v      = 4'b1111;
    v[col] = 1'b0;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab3_sync.sv
// ============================================================================
// Module   : lab3_sync
// Brief    : Parameterised-width two-flop synchroniser, resets to all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab3_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/lab3_keypad_scanner.sv
// ============================================================================
// Module   : lab3_keypad_scanner
// Brief    : 4x4 keypad scanner with debounce; one code + strobe per press.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab3_keypad_scanner
  import lab3_pkg::*;
#(
  parameter int SCAN_DIV        = 2400,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int c_cnt_max = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_col, w_col_nxt;
  logic [1:0]           r_row, w_row_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]           r_cols;
  logic [3:0]           r_key_code;
  logic                 r_key_valid;
  logic [3:0]           w_rs;
  logic                 w_row_bit;
  logic [1:0]           w_low_row;
  logic                 w_emit;

  lab3_sync #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rows),
    .o_q   (w_rs)
  );

  assign w_row_bit = w_rs[r_row];

  // Lowest-index low row wins when several are pressed on one column
  always_comb begin
    w_low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_rs[i]) w_low_row = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (r_cnt >= c_scan_last) begin
          w_cnt_nxt = '0;
          if (w_rs == 4'hF) begin
            w_col_nxt = r_col + 2'd1;
          end else begin
            w_row_nxt   = w_low_row;
            w_state_nxt = S_DEBOUNCE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (w_row_bit) begin
          w_cnt_nxt   = '0;
          w_col_nxt   = r_col + 2'd1;
          w_state_nxt = S_SCAN;
        end else if (r_cnt >= c_deb_last) begin
          w_cnt_nxt   = '0;
          w_emit      = 1'b1;
          w_state_nxt = S_EMIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_HELD;
      end
      S_HELD: begin
        // The cycle that first sees the row high already counts towards release
        if (w_row_bit) begin
          w_cnt_nxt   = c_cnt_w'(1);
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!w_row_bit) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HELD;
        end else if (r_cnt >= c_deb_last) begin
          w_cnt_nxt   = '0;
          w_col_nxt   = r_col + 2'd1;
          w_state_nxt = S_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_col_nxt   = 2'd0;
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_cnt       <= '0;
      r_cols      <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cols      <= col_drive(w_col_nxt);
      r_key_valid <= w_emit;
      if (w_emit) r_key_code <= KEYMAP[r_row][r_col];
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

endmodule

`default_nettype wire

// File: tb/tb_lab3_keypad_scanner.sv
// ============================================================================
// Module   : tb_lab3_keypad_scanner
// Brief    : Self-checking bench: physical keypad model plus event-level timing model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lab3_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;

  bit         pressed [4][4];
  bit         force_en = 1'b1;
  logic [3:0] force_val = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_strobe = 0;
  int last_strobe_cyc = -1;
  logic [3:0] last_strobe_code = 4'h0;

  logic [3:0] exp_map [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  lab3_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // A row reads low only when a pressed key sits on a currently driven column
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && cols[c] == 1'b0) rows[r] = 1'b0;
    if (force_en) rows = force_val;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      n_strobe++;
      last_strobe_cyc  = cyc;
      last_strobe_code = key_code;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] drv(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c[1:0]] = 1'b0;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic wait_col_start(input int c, output int e0, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    e0 = 0;
    for (int i = 0; i < 40; i++) begin
      prev = cols;
      tick(1);
      if (cols === drv(c) && prev !== drv(c)) begin
        ok = 1'b1;
        e0 = cyc;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL col_wait: cols=%b never started, required %b", cols, drv(c));
    end
  endtask

  // Strobe is due SD-1 cycles to the sample plus DB+1; release completes DB+2 after the raw rise
  task automatic do_keypress(input string name, input int r, input int c,
                             input int hold, input int nb, input bit fixed);
    int e0, s0, nc;
    bit ok;
    wait_col_start(c, e0, ok);
    if (!ok) return;
    s0 = n_strobe;
    pressed[r][c] = 1'b1;
    tick(SD + DB);
    n_tests++;
    if (n_strobe !== s0 + 1 || last_strobe_cyc !== e0 + SD + DB) begin
      n_fail++;
      $display("FAIL %s strobe: %0d strobes, last at cycle %0d; required 1 at cycle %0d",
               name, n_strobe - s0, last_strobe_cyc, e0 + SD + DB);
    end
    n_tests++;
    if (last_strobe_code !== exp_map[r][c]) begin
      n_fail++;
      $display("FAIL %s code: got %h, required %h", name, last_strobe_code, exp_map[r][c]);
    end
    tick(hold + 1);
    n_tests++;
    if (cols !== drv(c) || n_strobe !== s0 + 1 || key_code !== exp_map[r][c]) begin
      n_fail++;
      $display("FAIL %s held: cols=%b strobes=%0d code=%h; required cols=%b strobes=1 code=%h",
               name, cols, n_strobe - s0, key_code, drv(c), exp_map[r][c]);
    end
    for (int b = 0; b < nb; b++) begin
      pressed[r][c] = 1'b0;
      tick(fixed ? 2 : int'($urandom_range(1, 5)));
      pressed[r][c] = 1'b1;
      tick(fixed ? 2 : int'($urandom_range(1, 3)));
    end
    pressed[r][c] = 1'b0;
    tick(DB + 1);
    n_tests++;
    if (cols !== drv(c)) begin
      n_fail++;
      $display("FAIL %s early_resume: cols=%b, required %b", name, cols, drv(c));
    end
    tick(1);
    nc = (c + 1) % 4;
    n_tests++;
    if (cols !== drv(nc) || n_strobe !== s0 + 1) begin
      n_fail++;
      $display("FAIL %s resume: cols=%b strobes=%0d, required cols=%b strobes=1",
               name, cols, n_strobe - s0, drv(nc));
    end
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++;
    if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_values: cols=%b valid=%b code=%h, required 1110 0 0",
               cols, key_valid, key_code);
    end
    force_val = 4'hF;
    force_en  = 1'b0;
    reset     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_tests++;
      if (cols !== drv((k / SD) % 4)) begin
        n_fail++;
        $display("FAIL scan_step k=%0d: cols=%b, required %b", k, cols, drv((k / SD) % 4));
      end
      tick(1);
    end
    n_tests++;
    if (n_strobe !== 0) begin
      n_fail++;
      $display("FAIL idle_strobe: %0d strobes, required 0", n_strobe);
    end
  endtask

  task automatic test_press5();
    do_keypress("press5", 1, 1, 28, 0, 1'b0);
  endtask

  task automatic test_bounce();
    int e0, s0;
    bit ok;
    logic [3:0] kc;
    wait_col_start(3, e0, ok);
    if (!ok) return;
    s0 = n_strobe;
    kc = key_code;
    pressed[0][3] = 1'b1;
    tick(5);
    pressed[0][3] = 1'b0;
    tick(2);
    n_tests++;
    if (cols !== 4'b0111) begin
      n_fail++;
      $display("FAIL bounce_hold: cols=%b, required 0111", cols);
    end
    tick(1);
    n_tests++;
    if (cols !== 4'b1110 || n_strobe !== s0 || key_code !== kc) begin
      n_fail++;
      $display("FAIL bounce_abort: cols=%b strobes=%0d code=%h; required 1110 0 %h",
               cols, n_strobe - s0, key_code, kc);
    end
  endtask

  task automatic test_release_bounce();
    do_keypress("rel_bounce", 0, 3, 4, 5, 1'b1);
  endtask

  task automatic test_multikey();
    int e0, s0;
    bit ok;
    wait_col_start(1, e0, ok);
    if (!ok) return;
    s0 = n_strobe;
    pressed[0][1] = 1'b1;
    pressed[2][1] = 1'b1;
    tick(SD + DB);
    n_tests++;
    if (n_strobe !== s0 + 1 || last_strobe_code !== 4'h2 || last_strobe_cyc !== e0 + SD + DB) begin
      n_fail++;
      $display("FAIL multikey: strobes=%0d code=%h cycle=%0d; required 1 2 %0d",
               n_strobe - s0, last_strobe_code, last_strobe_cyc, e0 + SD + DB);
    end
    pressed[0][2] = 1'b1;
    tick(20);
    n_tests++;
    if (n_strobe !== s0 + 1 || cols !== 4'b1101) begin
      n_fail++;
      $display("FAIL other_col: strobes=%0d cols=%b; required 1 1101", n_strobe - s0, cols);
    end
    pressed[0][2] = 1'b0;
    tick(2);
    pressed[0][1] = 1'b0;
    pressed[2][1] = 1'b0;
    tick(DB + 2);
    n_tests++;
    if (cols !== 4'b1011) begin
      n_fail++;
      $display("FAIL multikey_resume: cols=%b, required 1011", cols);
    end
    tick(4 * SD);
    n_tests++;
    if (n_strobe !== s0 + 1) begin
      n_fail++;
      $display("FAIL multikey_extra: strobes=%0d, required 1", n_strobe - s0);
    end
  endtask

  task automatic test_random();
    int r, c;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      do_keypress($sformatf("rand%0d", i), r, c, $urandom_range(0, 20),
                  $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_held();
    int e0;
    bit ok;
    wait_col_start(1, e0, ok);
    if (!ok) return;
    pressed[3][1] = 1'b1;
    tick(SD + DB + 5);
    n_tests++;
    if (cols !== 4'b1101 || last_strobe_code !== 4'h0 || last_strobe_cyc !== e0 + SD + DB) begin
      n_fail++;
      $display("FAIL key0_held: cols=%b code=%h cycle=%0d; required 1101 0 %0d",
               cols, last_strobe_code, last_strobe_cyc, e0 + SD + DB);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid: cols=%b valid=%b code=%h, required 1110 0 0",
               cols, key_valid, key_code);
    end
    tick(2);
    clear_keys();
    reset = 1'b1;
    tick(SD - 1);
    n_tests++;
    if (cols !== 4'b1110) begin
      n_fail++;
      $display("FAIL restart_col0: cols=%b, required 1110", cols);
    end
    tick(1);
    n_tests++;
    if (cols !== 4'b1101) begin
      n_fail++;
      $display("FAIL restart_col1: cols=%b, required 1101", cols);
    end
  endtask

  initial begin
    clear_keys();
    test_reset();
    test_press5();
    test_bounce();
    test_release_bounce();
    test_multikey();
    test_random();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
